// File: rtl/oled_spi_pkg.sv
// Shared types and constants for the OLED SPI transmitter slot.
// The slot exposes data push, divisor, overflow clear and a read-only status word.
package oled_spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t SETUP    = 3'd1;
  localparam state_t SHIFT_LO = 3'd2;
  localparam state_t SHIFT_HI = 3'd3;
  localparam state_t HOLD     = 3'd4;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_DVSR = 2'd1;
  localparam logic [1:0] REG_CLR  = 2'd2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;

  function automatic logic [31:0] pack_status(input logic       busy,
                                              input logic       full,
                                              input logic       empty,
                                              input logic       ovf,
                                              input logic [3:0] count);
    logic [31:0] s;
    s                                   = '0;
    s[STAT_BUSY]                        = busy;
    s[STAT_FULL]                        = full;
    s[STAT_EMPTY]                       = empty;
    s[STAT_OVF]                         = ovf;
    s[STAT_COUNT_LSB+3:STAT_COUNT_LSB]  = count;
    return s;
  endfunction

endpackage

// File: rtl/oled_tx_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// Push while full and pop while empty are ignored; simultaneous push/pop keeps count.
module oled_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wr_data,
  output logic [7:0]            rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   cnt;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (cnt == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/oled_spi_core.sv
// Slot-mapped, write-only SPI mode 3 transmitter for the OLED command/data stream.
// Bytes queue in a TX FIFO and are shifted MSB-first with chip-select held across a burst.
module oled_spi_core
  import oled_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] DVSR_DEFAULT    = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        oled_sclk,
  output logic        oled_sdin,
  output logic        oled_cs_n
);

  logic                     wr_en;
  logic                     push;
  logic                     pop;
  logic [7:0]               fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;

  logic [15:0] dvsr;
  logic [15:0] wdvsr;
  logic [15:0] cnt;
  logic        tc;
  logic        ovf;
  state_t      state;
  logic [7:0]  shreg;
  logic [2:0]  bitc;
  logic        busy;
  logic        unused;

  assign unused = ^{read, addr[4:2], wr_data[31:16]};

  assign wr_en = cs & write;
  assign push  = wr_en && (addr[1:0] == REG_DATA);
  assign tc    = (cnt == wdvsr);
  assign busy  = (state != IDLE) || !fifo_empty;

  // Pop on leaving IDLE, or when chaining the next byte at the end of bit 7.
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == SHIFT_HI) && tc && (bitc == 3'd7)));

  oled_tx_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .wr_data(wr_data[7:0]),
    .rd_data(fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvsr <= DVSR_DEFAULT;
      ovf  <= 1'b0;
    end else begin
      if (wr_en && (addr[1:0] == REG_DVSR)) begin
        dvsr <= wr_data[15:0];
      end
      if (wr_en && (addr[1:0] == REG_CLR)) begin
        ovf <= 1'b0;
      end else if (push && fifo_full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == IDLE) || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      oled_cs_n <= 1'b1;
      oled_sclk <= 1'b1;
      oled_sdin <= 1'b0;
      shreg     <= '0;
      bitc      <= '0;
      wdvsr     <= DVSR_DEFAULT;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg     <= fifo_dout;
            oled_cs_n <= 1'b0;
            wdvsr     <= dvsr;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (tc) begin
            oled_sclk <= 1'b0;
            oled_sdin <= shreg[7];
            bitc      <= '0;
            state     <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (tc) begin
            oled_sclk <= 1'b1;
            state     <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tc) begin
            if (bitc != 3'd7) begin
              shreg     <= {shreg[6:0], 1'b0};
              oled_sdin <= shreg[6];
              bitc      <= bitc + 3'd1;
              oled_sclk <= 1'b0;
              state     <= SHIFT_LO;
            end else if (!fifo_empty) begin
              shreg     <= fifo_dout;
              oled_sdin <= fifo_dout[7];
              bitc      <= '0;
              oled_sclk <= 1'b0;
              state     <= SHIFT_LO;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tc) begin
            oled_cs_n <= 1'b1;
            oled_sdin <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr[1:0])
      REG_DATA: rd_data = pack_status(busy, fifo_full, fifo_empty, ovf, 4'(fifo_count));
      REG_DVSR: rd_data = {16'b0, dvsr};
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_oled_spi_core.sv
// Scoreboard bench for oled_spi_core: expected bytes and frame shapes are queued
// by the stimulus and retired by a monitor decoding the SPI pins.
module tb_oled_spi_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        oled_sclk;
  logic        oled_sdin;
  logic        oled_cs_n;

  typedef struct {
    int cyc;
    int bits;
  } frame_t;

  logic [7:0] exp_bytes[$];
  frame_t     exp_frames[$];

  int checks = 0;
  int errors = 0;
  int mon_bits = 0;
  int rise_total = 0;

  oled_spi_core dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .oled_sclk(oled_sclk),
    .oled_sdin(oled_sdin),
    .oled_cs_n(oled_cs_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end one time unit after a rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = {3'b0, a}; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    cs = 1'b1; read = 1'b1; addr = {3'b0, a};
    #1;
    check(name, rd_data, exp);
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int n = 0; n < 20000 && !done; n++) begin
      cs = 1'b1; read = 1'b1; addr = 5'd0;
      #1;
      if (!rd_data[0]) done = 1'b1;
      @(posedge clk); #1;
    end
    cs = 1'b0; read = 1'b0;
    check(name, {31'b0, done}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: decode bytes on SCLK rising edges and measure chip-select frames.
  initial begin
    logic       sclk_prev;
    logic [7:0] shv;
    int         lowcnt;
    frame_t     f;
    sclk_prev = 1'b1;
    shv = '0;
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lowcnt = 0;
        mon_bits = 0;
        sclk_prev = 1'b1;
      end else begin
        if (oled_sclk && !sclk_prev) begin
          rise_total++;
        end
        if (!oled_cs_n) begin
          lowcnt++;
          if (oled_sclk && !sclk_prev) begin
            shv = {shv[6:0], oled_sdin};
            mon_bits++;
            if (mon_bits % 8 == 0) begin
              if (exp_bytes.size() == 0) begin
                check("unexpected_byte", {24'b0, shv}, 32'hFFFF_FFFF);
              end else begin
                check("byte", {24'b0, shv}, {24'b0, exp_bytes.pop_front()});
              end
            end
          end
        end else if (lowcnt > 0) begin
          if (exp_frames.size() == 0) begin
            check("unexpected_frame", lowcnt, 0);
          end else begin
            f = exp_frames.pop_front();
            check("frame_cs_low_cycles", lowcnt, f.cyc);
            check("frame_rising_edges", mon_bits, f.bits);
          end
          lowcnt = 0;
          mon_bits = 0;
        end
        sclk_prev = oled_sclk;
      end
    end
  end

  initial begin
    int     snap;
    logic   hit;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_cs_n", {31'b0, oled_cs_n}, 32'd1);
    check("rst_sclk", {31'b0, oled_sclk}, 32'd1);
    check("rst_sdin", {31'b0, oled_sdin}, 32'd0);
    rd_chk(2'd0, 32'h4, "rst_status");
    rd_chk(2'd1, 32'h4, "rst_dvsr");
    rd_chk(2'd2, 32'h0, "rd_addr2");

    // Single byte, dvsr=1: 18*2 cycles low.
    wr(2'd1, 32'h1);
    rd_chk(2'd1, 32'h1, "dvsr_readback");
    exp_bytes.push_back(8'hA5);
    exp_frames.push_back('{36, 8});
    wr(2'd0, 32'hA5);
    wait_idle("t1_idle");
    rd_chk(2'd0, 32'h4, "t1_status");

    // Three-byte burst, dvsr=1: (2+48)*2 cycles low.
    exp_bytes.push_back(8'hAE);
    exp_bytes.push_back(8'hD5);
    exp_bytes.push_back(8'h80);
    exp_frames.push_back('{100, 24});
    wr(2'd0, 32'hAE);
    wr(2'd0, 32'hD5);
    wr(2'd0, 32'h80);
    wait_idle("t2_idle");

    // Overflow: first byte pops alongside the second push, so the tenth is dropped.
    wr(2'd1, 32'd100);
    for (int i = 0; i < 9; i++) exp_bytes.push_back(8'h10 + 8'(i));
    exp_frames.push_back('{146 * 101, 72});
    for (int i = 0; i < 10; i++) wr(2'd0, 32'h10 + i);
    rd_chk(2'd0, 32'h8B, "ovf_status");
    wr(2'd2, 32'hFFFF_FFFF);
    rd_chk(2'd0, 32'h83, "ovf_cleared");
    wait_idle("t3_idle");
    rd_chk(2'd0, 32'h4, "t3_status");

    // Divisor change mid-burst applies only to the next burst.
    wr(2'd1, 32'd3);
    exp_bytes.push_back(8'h3C);
    exp_bytes.push_back(8'hC3);
    exp_frames.push_back('{34 * 4, 16});
    wr(2'd0, 32'h3C);
    wr(2'd0, 32'hC3);
    wr(2'd1, 32'd0);
    wait_idle("t4a_idle");
    rd_chk(2'd1, 32'h0, "dvsr0_readback");
    exp_bytes.push_back(8'h5A);
    exp_frames.push_back('{18, 8});
    wr(2'd0, 32'h5A);
    wait_idle("t4b_idle");

    // Reset in the middle of bit 4 with more bytes queued.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    wr(2'd0, 32'h33);
    hit = 1'b0;
    for (int n = 0; n < 500 && !hit; n++) begin
      @(posedge clk); #1;
      if (mon_bits >= 4) hit = 1'b1;
    end
    check("t5_reach_bit4", {31'b0, hit}, 32'd1);
    @(posedge clk); #1;
    check("t5_cs_active", {31'b0, oled_cs_n}, 32'd0);
    reset = 1'b1;
    #1;
    check("t5_async_cs_n", {31'b0, oled_cs_n}, 32'd1);
    check("t5_async_sclk", {31'b0, oled_sclk}, 32'd1);
    check("t5_async_sdin", {31'b0, oled_sdin}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd_chk(2'd0, 32'h4, "t5_status");
    snap = rise_total;
    repeat (60) @(posedge clk);
    #1;
    check("t5_no_sclk_edges", rise_total, snap);
    check("t5_cs_idle", {31'b0, oled_cs_n}, 32'd1);

    check("bytes_outstanding", exp_bytes.size(), 0);
    check("frames_outstanding", exp_frames.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oled_spi_core.md
Name: oled_spi_core

Overview:
Slot-mapped SPI transmitter carrying the OLED command/data byte stream. It pairs with the OLED GPIO core, which drives dc/reset/vbatc/vddc. Software pushes bytes into a small TX FIFO. A shift FSM serialises them MSB-first in SPI mode 3 (SCLK idles high, data changes on falling edge, sampled on rising edge), keeping chip-select asserted across back-to-back bytes. The OLED is write-only, so there is no MISO.

Parameters:
FIFO_DEPTH_LOG2, 3, TX FIFO holds 2**FIFO_DEPTH_LOG2 bytes (8).
DVSR_DEFAULT, 4, reset value of the 16-bit divisor; SCLK half-period = (dvsr+1) clk cycles, i.e. 10 MHz at 100 MHz clk.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  slot select
read  in  1  slot read strobe (reads have no side effects)
write  in  1  slot write strobe
addr  in  5  register address; only addr[1:0] decoded
wr_data  in  32  write data
rd_data  out  32  read data, combinational mux on addr[1:0]
oled_sclk  out  1  SPI clock, idles 1
oled_sdin  out  1  SPI data, 0 when idle
oled_cs_n  out  1  chip select, active low, idles 1

Behaviour:
- Reset values: oled_cs_n=1, oled_sclk=1, oled_sdin=0, FIFO empty, dvsr=DVSR_DEFAULT, overflow=0, FSM=IDLE.
- Write, addr 0: push wr_data[7:0]. If the registered full flag is set, the byte is dropped and sticky overflow is set. This holds even if a pop occurs in the same cycle.
- Write, addr 1: dvsr <= wr_data[15:0].
- Write, addr 2: clear overflow (data ignored).
- Write, addr 3: no effect.
- Read, addr 0 (status):
  - bit0 busy (FSM != IDLE or FIFO non-empty)
  - bit1 full
  - bit2 empty
  - bit3 overflow
  - bits[7:4] FIFO count
  - other bits 0
- Read, addr 1: {16'b0, dvsr}. Reads of addr 2 and 3 return 0.
- Working divisor: dvsr is copied into a working divisor only on leaving IDLE. A dvsr write during a burst affects the next burst only.
- Half-period counter: counts 0..wdvsr; the terminal count (tc) ends a phase.
- FSM states:
  - IDLE: when FIFO non-empty, pop into the 8-bit shift register, cs_n<=0, wdvsr<=dvsr, go SETUP.
  - SETUP: on tc, sclk<=0, sdin<=shreg[7], bit counter=0, go SHIFT_LO.
  - SHIFT_LO: on tc, sclk<=1 (slave samples), go SHIFT_HI.
  - SHIFT_HI: on tc,
    - if bit<7: shift left, sclk<=0, sdin<=next bit, go SHIFT_LO;
    - else if FIFO non-empty: pop, sclk<=0, sdin<=new bit7, go SHIFT_LO (cs_n stays 0);
    - else go HOLD.
  - HOLD: on tc, cs_n<=1, go IDLE.
- Latency: a write to an empty FIFO in cycle N makes the FIFO non-empty in N+1. The FSM pops in N+1, and oled_cs_n is low from edge N+2.
- Single-byte frame: cs_n low for 18*(dvsr+1) cycles.
- k-byte burst: cs_n low for (2+16k)*(dvsr+1) cycles, with no gap between bytes.
- Boundary rules:
  - dvsr=0 is legal: SCLK = clk/2.
  - A FIFO push and pop in the same cycle is legal when not full; count is unchanged.
  - Reset mid-frame returns all outputs to reset values immediately (async) and discards FIFO contents.
- The core has no coupling to oled_dc. Software waits for busy=0 before toggling dc.

Decomposition:
- Package oled_spi_pkg holds:
  - typedef enum state_t {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD};
  - register address constants REG_DATA=0, REG_DVSR=1, REG_CLR=2;
  - status bit index constants.
- One sub-module, oled_tx_fifo: synchronous byte FIFO with push/pop/full/empty/count, async active-high reset.

Test Plan:
- After reset: read addr 0 returns 0x00000004; cs_n=1, sclk=1, sdin=0.
- dvsr=1, push 0xA5 → sdin at the 8 SCLK rising edges is 1,0,1,0,0,1,0,1; cs_n low exactly 36 clk; status then 0x4.
- dvsr=1, push 0xAE,0xD5,0x80 back-to-back → cs_n low continuously for 100 clk; 24 rising edges; bytes received in order.
- dvsr=100, push 10 bytes on consecutive cycles → bytes 0..8 transmitted, byte 9 dropped; overflow bit3=1; write addr 2 clears it.
- Write dvsr=0 mid-burst with dvsr=3 → current burst keeps 4-cycle half-periods; next burst uses 1-cycle half-periods.
- Assert reset during bit 4 of a byte with 3 bytes queued → outputs at reset values within the same cycle; status reads 0x4 after release; no further SCLK edges.
